// File: rtl/riscv_core_pkg.sv
// Shared core definitions: PC width, halfword type, RVC detection and
// the halfword-count encoding used between the realigner and its queue.
package riscv_core_pkg;

  localparam int XLEN = 64;

  typedef logic [15:0] hw_t;

  localparam hw_t RVC_NOP = 16'h0001;

  typedef enum logic [1:0] {
    HW_NONE = 2'd0,
    HW_ONE  = 2'd1,
    HW_TWO  = 2'd2
  } hwcnt_e;

  // Any halfword whose low two bits are not 2'b11 starts a 16-bit instruction
  function automatic logic is_rvc(input hw_t hw);
    return (hw[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/riscv_core_instrealign_if.sv
// Fetch-side and decode-side handshakes of the instruction realigner.
// The slave modport is the realigner; the master modport is its environment.
interface riscv_core_instrealign_if #(
  parameter int XLEN = riscv_core_pkg::XLEN
);

  logic            i_instrealign_fvalid;
  logic            o_instrealign_fready;
  logic [31:0]     i_instrealign_fword;
  logic            o_instrealign_valid;
  logic            i_instrealign_ready;
  logic [31:0]     o_instrealign_instr;
  logic [XLEN-1:0] o_instrealign_pc;
  logic            o_instrealign_compressed;

  modport slave (
    input  i_instrealign_fvalid,
    input  i_instrealign_fword,
    input  i_instrealign_ready,
    output o_instrealign_fready,
    output o_instrealign_valid,
    output o_instrealign_instr,
    output o_instrealign_pc,
    output o_instrealign_compressed
  );

  modport master (
    output i_instrealign_fvalid,
    output i_instrealign_fword,
    output i_instrealign_ready,
    input  o_instrealign_fready,
    input  o_instrealign_valid,
    input  o_instrealign_instr,
    input  o_instrealign_pc,
    input  o_instrealign_compressed
  );

endinterface

// File: rtl/riscv_core_instrealign_hwq.sv
// Circular halfword queue: up to two halfwords pushed and up to two popped
// per cycle, with a flush that empties it. Head and next-to-head are exposed.
module riscv_core_instrealign_hwq
  import riscv_core_pkg::*;
#(
  parameter  int BUF_HW = 4,
  localparam int PW     = $clog2(BUF_HW),
  localparam int CW     = $clog2(BUF_HW + 1)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_flush,
  input  hwcnt_e        i_pushN,
  input  hw_t           i_pushHw0,
  input  hw_t           i_pushHw1,
  input  hwcnt_e        i_popN,
  output logic [CW-1:0] o_count,
  output hw_t           o_head0,
  output hw_t           o_head1
);

  hw_t           r_mem [BUF_HW];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  // Pointers advance modulo the depth, which need not be a power of two
  function automatic logic [PW-1:0] ptrAdd(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= BUF_HW) s = s - BUF_HW;
    return PW'(s);
  endfunction

  // Storage, pointers and occupancy; flush empties the queue ahead of any push or pop
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < BUF_HW; i++) r_mem[i] <= RVC_NOP;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_pushN != HW_NONE) r_mem[r_wr] <= i_pushHw0;
      if (i_pushN == HW_TWO)  r_mem[ptrAdd(r_wr, 1)] <= i_pushHw1;
      r_wr    <= ptrAdd(r_wr, int'(i_pushN));
      r_rd    <= ptrAdd(r_rd, int'(i_popN));
      r_count <= r_count + CW'(i_pushN) - CW'(i_popN);
    end
  end

  assign o_count = r_count;
  assign o_head0 = r_mem[r_rd];
  assign o_head1 = r_mem[ptrAdd(r_rd, 1)];

endmodule

// File: rtl/riscv_core_instrealign.sv
// Instruction realigner between fetch and decode: turns aligned 32-bit fetch
// words into one whole 16- or 32-bit instruction per handshake, tracking the PC.
module riscv_core_instrealign #(
  parameter int              XLEN     = riscv_core_pkg::XLEN,
  parameter int              BUF_HW   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                      i_instrealign_clk,
  input logic                      i_instrealign_rstn,
  input logic                      i_instrealign_flush,
  input logic [XLEN-1:0]           i_instrealign_flushpc,
  riscv_core_instrealign_if.slave  io_instrealign
);

  import riscv_core_pkg::*;

  localparam int CW = $clog2(BUF_HW + 1);

  logic [CW-1:0]   w_count;
  hw_t             w_head0;
  hw_t             w_head1;
  hw_t             w_pushHw0;
  hwcnt_e          w_pushN;
  hwcnt_e          w_popN;
  logic            w_comp;
  logic            w_valid;
  logic            w_fready;
  logic            w_accept;
  logic            w_fire;
  logic [XLEN-1:0] r_pc;
  logic            r_dropLo;

  riscv_core_instrealign_hwq #(
    .BUF_HW (BUF_HW)
  ) u_hwq (
    .i_clk     (i_instrealign_clk),
    .i_rstn    (i_instrealign_rstn),
    .i_flush   (i_instrealign_flush),
    .i_pushN   (w_pushN),
    .i_pushHw0 (w_pushHw0),
    .i_pushHw1 (io_instrealign.i_instrealign_fword[31:16]),
    .i_popN    (w_popN),
    .o_count   (w_count),
    .o_head0   (w_head0),
    .o_head1   (w_head1)
  );

  // Head decode uses only queue state, so no input reaches an output combinationally
  assign w_comp   = is_rvc(w_head0);
  assign w_valid  = ((w_count != '0) && w_comp) || (w_count >= CW'(2));
  assign w_fready = (w_count <= CW'(BUF_HW - 2));

  assign w_accept  = io_instrealign.i_instrealign_fvalid && w_fready && !i_instrealign_flush;
  assign w_fire    = w_valid && io_instrealign.i_instrealign_ready && !i_instrealign_flush;
  assign w_pushHw0 = r_dropLo ? io_instrealign.i_instrealign_fword[31:16]
                              : io_instrealign.i_instrealign_fword[15:0];
  assign w_pushN   = !w_accept ? HW_NONE : (r_dropLo ? HW_ONE : HW_TWO);
  assign w_popN    = !w_fire   ? HW_NONE : (w_comp   ? HW_ONE : HW_TWO);

  // Head PC follows consumed instructions; a redirect reloads it and arms the odd-halfword drop
  always_ff @(posedge i_instrealign_clk or negedge i_instrealign_rstn) begin
    if (!i_instrealign_rstn) begin
      r_pc     <= RESET_PC;
      r_dropLo <= 1'b0;
    end else if (i_instrealign_flush) begin
      r_pc     <= i_instrealign_flushpc;
      r_dropLo <= i_instrealign_flushpc[1];
    end else begin
      if (w_fire)   r_pc     <= r_pc + (w_comp ? XLEN'(2) : XLEN'(4));
      if (w_accept) r_dropLo <= 1'b0;
    end
  end

  assign io_instrealign.o_instrealign_fready     = w_fready;
  assign io_instrealign.o_instrealign_valid      = w_valid;
  assign io_instrealign.o_instrealign_pc         = r_pc;
  assign io_instrealign.o_instrealign_compressed = (w_count != '0) && w_comp;
  assign io_instrealign.o_instrealign_instr      = (w_count == '0) ? 32'h0 :
                                                   (w_comp ? {16'h0, w_head0} : {w_head1, w_head0});

endmodule

// File: tb/tb_riscv_core_instrealign.sv
// Directed bench for the instruction realigner: alignment, straddling,
// redirects, back-pressure and asynchronous reset, with hand-computed results.
module tb_riscv_core_instrealign;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic [63:0] flushpc;
  logic        rdy;
  int          checks;
  int          errors;

  riscv_core_instrealign_if #(.XLEN(64)) bus ();

  riscv_core_instrealign #(
    .XLEN     (64),
    .BUF_HW   (4),
    .RESET_PC (64'h0)
  ) dut (
    .i_instrealign_clk     (clk),
    .i_instrealign_rstn    (rstn),
    .i_instrealign_flush   (flush),
    .i_instrealign_flushpc (flushpc),
    .io_instrealign        (bus)
  );

  // Free-running core clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic fv, input logic [31:0] fw, input logic fl,
                               input logic [63:0] fpc, input logic rd);
    bus.i_instrealign_fvalid = fv;
    bus.i_instrealign_fword  = fw;
    bus.i_instrealign_ready  = rd;
    flush   = fl;
    flushpc = fpc;
  endtask

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic expValid, input logic [31:0] expInstr,
                             input logic [63:0] expPc, input logic expComp);
    checkVal({tag, "_valid"}, 64'(bus.o_instrealign_valid), 64'(expValid));
    checkVal({tag, "_pc"}, bus.o_instrealign_pc, expPc);
    if (expValid) begin
      checkVal({tag, "_instr"}, 64'(bus.o_instrealign_instr), 64'(expInstr));
      checkVal({tag, "_comp"}, 64'(bus.o_instrealign_compressed), 64'(expComp));
    end
  endtask

  task automatic pushWord(input logic [31:0] w);
    applyStimulus(1'b1, w, 1'b0, 64'h0, rdy);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0, rdy);
  endtask

  task automatic flushTo(input logic [63:0] pc);
    applyStimulus(1'b0, 32'h0, 1'b1, pc, rdy);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0, rdy);
  endtask

  // Directed sequence
  initial begin
    logic [31:0] wl [4];
    logic [31:0] eInstr [6];
    logic [63:0] ePc [6];
    logic        eComp [6];
    int          wIdx;
    int          oIdx;
    logic        fv;
    logic        acc;

    wl = '{32'h45014505, 32'h00A00513, 32'h00094581, 32'h00000013};
    eInstr = '{32'h00004505, 32'h00004501, 32'h00A00513, 32'h00004581, 32'h00000009, 32'h00000013};
    ePc    = '{64'h3000, 64'h3002, 64'h3004, 64'h3008, 64'h300A, 64'h300C};
    eComp  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    checks = 0;
    errors = 0;
    rdy    = 1'b0;
    rstn   = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick();
    tick();

    // Reset values
    checkVal("rst_valid", 64'(bus.o_instrealign_valid), 64'h0);
    checkVal("rst_instr", 64'(bus.o_instrealign_instr), 64'h0);
    checkVal("rst_comp", 64'(bus.o_instrealign_compressed), 64'h0);
    checkVal("rst_pc", bus.o_instrealign_pc, 64'h0);
    checkVal("rst_fready", 64'(bus.o_instrealign_fready), 64'h1);
    rstn = 1'b1;
    tick();

    // Aligned 32-bit instruction
    rdy = 1'b1;
    flushTo(64'h1000);
    checkOutput("t1_flush", 1'b0, 32'h0, 64'h1000, 1'b0);
    pushWord(32'h00000013);
    checkOutput("t1_instr", 1'b1, 32'h00000013, 64'h1000, 1'b0);
    tick();
    checkOutput("t1_empty", 1'b0, 32'h0, 64'h1004, 1'b0);

    // Two RVC instructions in one word
    flushTo(64'h1000);
    pushWord(32'h00014501);
    checkOutput("t2_lo", 1'b1, 32'h00004501, 64'h1000, 1'b1);
    tick();
    checkOutput("t2_hi", 1'b1, 32'h00000001, 64'h1002, 1'b1);
    tick();
    checkOutput("t2_empty", 1'b0, 32'h0, 64'h1004, 1'b0);

    // 32-bit instruction straddling two fetch words
    flushTo(64'h1000);
    pushWord(32'h00934505);
    checkOutput("t3_rvc", 1'b1, 32'h00004505, 64'h1000, 1'b1);
    tick();
    checkOutput("t3_wait0", 1'b0, 32'h0, 64'h1002, 1'b0);
    tick();
    checkOutput("t3_wait1", 1'b0, 32'h0, 64'h1002, 1'b0);
    pushWord(32'hFFFF0010);
    checkOutput("t3_straddle", 1'b1, 32'h00100093, 64'h1002, 1'b0);
    tick();
    checkOutput("t3_partial", 1'b0, 32'h0, 64'h1006, 1'b0);

    // Redirect to an odd halfword drops the low half of the first word
    flushTo(64'h2002);
    pushWord(32'h4585ABCD);
    checkOutput("t4_first", 1'b1, 32'h00004585, 64'h2002, 1'b1);
    tick();
    checkOutput("t4_empty", 1'b0, 32'h0, 64'h2004, 1'b0);

    // Back-pressure: fill while decode stalls, then drain in order
    flushTo(64'h3000);
    rdy = 1'b0;
    applyStimulus(1'b1, wl[0], 1'b0, 64'h0, 1'b0);
    tick();
    wIdx = 1;
    checkVal("t5_fready_c1", 64'(bus.o_instrealign_fready), 64'h1);
    applyStimulus(1'b1, wl[1], 1'b0, 64'h0, 1'b0);
    tick();
    wIdx = 2;
    checkVal("t5_fready_c2", 64'(bus.o_instrealign_fready), 64'h0);
    applyStimulus(1'b1, wl[2], 1'b0, 64'h0, 1'b0);
    repeat (4) tick();
    checkVal("t5_fready_full", 64'(bus.o_instrealign_fready), 64'h0);
    checkOutput("t5_hold", 1'b1, 32'h00004505, 64'h3000, 1'b1);
    rdy  = 1'b1;
    oIdx = 0;
    for (int cyc = 0; cyc < 40 && oIdx < 6; cyc++) begin
      if (bus.o_instrealign_valid) begin
        checkVal("t5_stream_instr", 64'(bus.o_instrealign_instr), 64'(eInstr[oIdx]));
        checkVal("t5_stream_pc", bus.o_instrealign_pc, ePc[oIdx]);
        checkVal("t5_stream_comp", 64'(bus.o_instrealign_compressed), 64'(eComp[oIdx]));
        oIdx++;
      end
      fv = (wIdx < 4);
      applyStimulus(fv, fv ? wl[wIdx] : 32'h0, 1'b0, 64'h0, 1'b1);
      acc = fv && bus.o_instrealign_fready;
      tick();
      if (acc) wIdx++;
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    checkVal("t5_stream_count", 64'(oIdx), 64'd6);
    checkVal("t5_words_taken", 64'(wIdx), 64'd4);
    checkOutput("t5_drained", 1'b0, 32'h0, 64'h3010, 1'b0);

    // Redirect, fetch word and output handshake all in one cycle
    flushTo(64'h1000);
    pushWord(32'h00014501);
    checkOutput("t6_pre", 1'b1, 32'h00004501, 64'h1000, 1'b1);
    applyStimulus(1'b1, 32'h45054505, 1'b1, 64'h4000, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    checkOutput("t6_flushed", 1'b0, 32'h0, 64'h4000, 1'b0);
    checkVal("t6_fready", 64'(bus.o_instrealign_fready), 64'h1);
    pushWord(32'h00000013);
    checkOutput("t6_first", 1'b1, 32'h00000013, 64'h4000, 1'b0);
    tick();
    checkOutput("t6_empty", 1'b0, 32'h0, 64'h4004, 1'b0);

    // Asynchronous reset in mid-stream
    pushWord(32'h00014501);
    checkOutput("t6_before_rst", 1'b1, 32'h00004501, 64'h4004, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("t6_rst_async", 1'b0, 32'h0, 64'h0, 1'b0);
    checkVal("t6_rst_fready", 64'(bus.o_instrealign_fready), 64'h1);
    #1;
    rstn = 1'b1;
    tick();
    pushWord(32'h00000013);
    checkOutput("t6_after_rst", 1'b1, 32'h00000013, 64'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
